cheri_tbre_engine: RTL and testbench
====================================

// Module: cheri_tbre_engine
// PURPOSE
//  Background revocation engine: sweeps [cfg_start, cfg_end) in 8-byte capability steps and issues one cap load per slot via the LSU.
//  Consumes the verdict of the downstream revocation-check stage (tbre_trvk_en/clrtag, 3 cycles after the load response).
//  When the verdict is "revoked", stores the slot back with its tag cleared.
//  Sits beside the CPU LSU port; lowest-priority LSU requester.
// PARAMETERS
//  ChkTimeout  8   cycles after load resp to wait for tbre_trvk_en_i before flagging error and skipping the slot
//  CntW        16  width of revoked-slot counter (saturating)
// PORTS
//  clk_i               in   1        clock
//  rst_ni              in   1        async active-low reset
//  cfg_go_i            in   1        pulse: latch cfg_start_i/cfg_end_i and start the sweep (ignored while busy)
//  cfg_abort_i         in   1        pulse: stop after the outstanding LSU transaction completes
//  cfg_start_i         in   32       sweep start byte address; bits[2:0] forced to 0
//  cfg_end_i           in   32       sweep end (exclusive); bits[2:0] forced to 0
//  stat_busy_o         out  1        sweep in progress
//  stat_done_o         out  1        1-cycle pulse when the sweep finishes or the abort completes
//  stat_err_o          out  1        sticky: load error or check timeout since last go
//  stat_rvk_cnt_o      out  CntW     slots revoked since last go
//  tbre_lsu_req_o      out  1        LSU request valid; held until accepted
//  tbre_lsu_we_o       out  1        1 = store-back, 0 = cap load
//  tbre_lsu_addr_o     out  32       slot address
//  tbre_lsu_wdata_o    out  32       store data (address word of the loaded cap)
//  tbre_lsu_wcap_o     out  reg_cap_t store cap metadata; .valid always 0
//  lsu_tbre_req_done_i in   1        LSU accepted the current request
//  lsu_tbre_resp_valid_i in 1        LSU response for the TBRE request
//  lsu_tbre_resp_err_i in   1        response carries a bus error
//  rf_wdata_lsu_i      in   32       loaded data word (valid with the resp)
//  rf_wcap_lsu_i       in   reg_cap_t loaded cap metadata (valid with the resp)
//  tbre_trvk_en_i      in   1        verdict strobe from the revocation-check stage
//  tbre_trvk_clrtag_i  in   1        verdict: clear the tag of this slot
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; tbre_lsu_wcap_o = NULL_REG_CAP; counters/flags 0.
//  - FSM: IDLE -go-> (start>=end ? DONE : LD_REQ); LD_REQ -req_done-> LD_WAIT;
//    LD_WAIT -resp & err-> set stat_err, NEXT; LD_WAIT -resp & ~err-> capture data/cap, CHK_WAIT;
//    CHK_WAIT -trvk_en & clrtag-> ST_REQ; -trvk_en & ~clrtag-> NEXT; -timeout-> set stat_err, NEXT;
//    ST_REQ -req_done-> ST_WAIT; ST_WAIT -resp-> count++ (sat), err sets stat_err, NEXT;
//    NEXT: addr+=8; (abort_pending | addr>=end) ? DONE : LD_REQ; DONE: pulse stat_done_o, -> IDLE.
//  - One transaction outstanding at most; req_o/we_o/addr_o/wdata_o/wcap_o are stable while req_o=1 and not accepted.
//  - Verdicts: tbre_trvk_en_i outside CHK_WAIT is ignored; verdict latency from resp is nominally 3 cycles.
//  - Timeout counter starts at the load resp; expires after ChkTimeout cycles with no en.
//  - Store-back data: captured rf_wdata_lsu_i and rf_wcap_lsu_i with .valid forced 0; no other field changed.
//  - Abort: sets abort_pending; in IDLE/DONE it is ignored; in LD_REQ/ST_REQ before acceptance -> drop req, go DONE;
//    otherwise complete the current load or store and go DONE at NEXT.
//    If the slot was judged revoked, finish its store-back first.
//  - Address arithmetic: 32-bit unsigned; NEXT compares addr+8 with a 33-bit result; carry out -> DONE (no wrap).
//  - stat_busy_o = state not in {IDLE}. go while busy ignored; go + abort in the same cycle: go wins, abort dropped.
//  - stat_err_o, stat_rvk_cnt_o cleared on accepted go.
//  - Concurrent CPU stores to a slot between load and store-back are not arbitrated here; software quiesces the heap.
// STRUCTURE
//  - cheri_pkg: reg_cap_t and NULL_REG_CAP (existing); add tbre_state_e enum
//    {IDLE, LD_REQ, LD_WAIT, CHK_WAIT, ST_REQ, ST_WAIT, NEXT, DONE}.
//  - Single flat module; no sub-module. Datapath: addr/end regs, data/cap capture regs, timeout and revoked counters.
// TESTING
//  - go start=0x8000_0000 end=0x8000_0018, all verdicts clrtag=0 -> 3 loads at +0,+8,+10, no stores, done pulse, cnt=0.
//  - Same range, verdict clrtag=1 on slot 0x8000_0008 -> store at 0x8000_0008 with wcap.valid=0 and wdata equal to the loaded word; cnt=1.
//  - start=end=0x100 -> no LSU req, stat_done_o pulses 1 cycle after go.
//  - Load resp with err=1 at slot 0x10 -> no store, stat_err_o=1, sweep continues to 0x18.
//  - Withhold trvk_en after a good load -> after ChkTimeout=8 cycles stat_err_o=1, next load issued.
//  - Abort during LD_WAIT with range of 4 slots -> current load completes, no further req, done pulse, busy=0.

Source files
------------

// File: rtl/cheri_tbre_engine_pkg.sv
// cheri_tbre_engine_pkg: register-capability format and TBRE sweep state encoding.
package cheri_tbre_engine_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] exp;
        logic [8:0] top;
        logic [8:0] base;
        logic [5:0] cperms;
        logic [2:0] otype;
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '{
        valid:  1'b0,
        exp:    5'd24,
        top:    9'h100,
        base:   9'h000,
        cperms: 6'h00,
        otype:  3'h0
    };

    localparam logic [2:0] TBRE_IDLE     = 3'd0;
    localparam logic [2:0] TBRE_LD_REQ   = 3'd1;
    localparam logic [2:0] TBRE_LD_WAIT  = 3'd2;
    localparam logic [2:0] TBRE_CHK_WAIT = 3'd3;
    localparam logic [2:0] TBRE_ST_REQ   = 3'd4;
    localparam logic [2:0] TBRE_ST_WAIT  = 3'd5;
    localparam logic [2:0] TBRE_NEXT     = 3'd6;
    localparam logic [2:0] TBRE_DONE     = 3'd7;

endpackage

// File: rtl/cheri_tbre_engine_if.sv
// cheri_tbre_engine_if: LSU request/response port between the TBRE and the LSU.
interface cheri_tbre_engine_if;
    import cheri_tbre_engine_pkg::*;

    logic        tbre_lsu_req_o;
    logic        tbre_lsu_we_o;
    logic [31:0] tbre_lsu_addr_o;
    logic [31:0] tbre_lsu_wdata_o;
    reg_cap_t    tbre_lsu_wcap_o;
    logic        lsu_tbre_req_done_i;
    logic        lsu_tbre_resp_valid_i;
    logic        lsu_tbre_resp_err_i;
    logic [31:0] rf_wdata_lsu_i;
    reg_cap_t    rf_wcap_lsu_i;

    modport master (
        output tbre_lsu_req_o, tbre_lsu_we_o, tbre_lsu_addr_o, tbre_lsu_wdata_o, tbre_lsu_wcap_o,
        input  lsu_tbre_req_done_i, lsu_tbre_resp_valid_i, lsu_tbre_resp_err_i,
               rf_wdata_lsu_i, rf_wcap_lsu_i
    );

    modport slave (
        input  tbre_lsu_req_o, tbre_lsu_we_o, tbre_lsu_addr_o, tbre_lsu_wdata_o, tbre_lsu_wcap_o,
        output lsu_tbre_req_done_i, lsu_tbre_resp_valid_i, lsu_tbre_resp_err_i,
               rf_wdata_lsu_i, rf_wcap_lsu_i
    );

endinterface

// File: rtl/cheri_tbre_engine.sv
// cheri_tbre_engine: background revocation sweep; loads each 8-byte slot and
// stores it back tag-cleared when the downstream check judges it revoked.
module cheri_tbre_engine
    import cheri_tbre_engine_pkg::*;
#(
    parameter int unsigned ChkTimeout = 8,
    parameter int unsigned CntW       = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_go_i,
    input  logic                cfg_abort_i,
    input  logic [31:0]         cfg_start_i,
    input  logic [31:0]         cfg_end_i,
    output logic                stat_busy_o,
    output logic                stat_done_o,
    output logic                stat_err_o,
    output logic [CntW-1:0]     stat_rvk_cnt_o,
    cheri_tbre_engine_if.master lsu,
    input  logic                tbre_trvk_en_i,
    input  logic                tbre_trvk_clrtag_i
);

    localparam int unsigned TmoW = $clog2(ChkTimeout + 1);

    logic [2:0]      r_state;
    logic [31:0]     r_addr;
    logic [31:0]     r_end;
    logic [31:0]     r_data;
    reg_cap_t        r_cap;
    logic [TmoW-1:0] r_tmo;
    logic [CntW-1:0] r_cnt;
    logic            r_err;
    logic            r_abort;
    logic [31:0]     w_start;
    logic [31:0]     w_end;
    logic [32:0]     w_nxt;
    reg_cap_t        w_cap;

    assign w_start = cfg_start_i & 32'hFFFF_FFF8;
    assign w_end   = cfg_end_i & 32'hFFFF_FFF8;
    assign w_nxt   = {1'b0, r_addr} + 33'd8;

    always_comb begin
        w_cap       = lsu.rf_wcap_lsu_i;
        w_cap.valid = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= TBRE_IDLE;
            r_addr  <= '0;
            r_end   <= '0;
            r_data  <= '0;
            r_cap   <= NULL_REG_CAP;
            r_tmo   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            if (cfg_abort_i && r_state != TBRE_IDLE && r_state != TBRE_DONE) r_abort <= 1'b1;
            case (r_state)
                TBRE_IDLE: if (cfg_go_i) begin
                    r_addr  <= w_start;
                    r_end   <= w_end;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_abort <= 1'b0;
                    r_state <= (w_start >= w_end) ? TBRE_DONE : TBRE_LD_REQ;
                end
                // An abort only drops a request the LSU has not yet taken.
                TBRE_LD_REQ, TBRE_ST_REQ: begin
                    if (lsu.lsu_tbre_req_done_i)
                        r_state <= (r_state == TBRE_LD_REQ) ? TBRE_LD_WAIT : TBRE_ST_WAIT;
                    else if (cfg_abort_i)
                        r_state <= TBRE_DONE;
                end
                TBRE_LD_WAIT: if (lsu.lsu_tbre_resp_valid_i) begin
                    if (lsu.lsu_tbre_resp_err_i) begin
                        r_err   <= 1'b1;
                        r_state <= TBRE_NEXT;
                    end else begin
                        r_data  <= lsu.rf_wdata_lsu_i;
                        r_cap   <= w_cap;
                        r_tmo   <= '0;
                        r_state <= TBRE_CHK_WAIT;
                    end
                end
                TBRE_CHK_WAIT: begin
                    if (tbre_trvk_en_i) begin
                        r_state <= tbre_trvk_clrtag_i ? TBRE_ST_REQ : TBRE_NEXT;
                    end else if (r_tmo == TmoW'(ChkTimeout - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= TBRE_NEXT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                TBRE_ST_WAIT: if (lsu.lsu_tbre_resp_valid_i) begin
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    if (lsu.lsu_tbre_resp_err_i) r_err <= 1'b1;
                    r_state <= TBRE_NEXT;
                end
                // 33-bit compare: a carry out of the address ends the sweep instead of wrapping.
                TBRE_NEXT: begin
                    r_addr  <= w_nxt[31:0];
                    r_state <= (r_abort || cfg_abort_i || w_nxt >= {1'b0, r_end}) ? TBRE_DONE : TBRE_LD_REQ;
                end
                TBRE_DONE: r_state <= TBRE_IDLE;
                default:   r_state <= TBRE_IDLE;
            endcase
        end
    end

    assign lsu.tbre_lsu_req_o   = (r_state == TBRE_LD_REQ) || (r_state == TBRE_ST_REQ);
    assign lsu.tbre_lsu_we_o    = r_state == TBRE_ST_REQ;
    assign lsu.tbre_lsu_addr_o  = r_addr;
    assign lsu.tbre_lsu_wdata_o = r_data;
    assign lsu.tbre_lsu_wcap_o  = r_cap;
    assign stat_busy_o          = r_state != TBRE_IDLE;
    assign stat_done_o          = r_state == TBRE_DONE;
    assign stat_err_o           = r_err;
    assign stat_rvk_cnt_o       = r_cnt;

endmodule

// File: tb/tb_cheri_tbre_engine.sv
// tb_cheri_tbre_engine: table, randomized and hand-written sweeps checked
// against a slot-by-slot model of which loads and store-backs must appear.
`timescale 1ns/1ps
module tb_cheri_tbre_engine;
    import cheri_tbre_engine_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_go_i = 1'b0;
    logic        cfg_abort_i = 1'b0;
    logic [31:0] cfg_start_i = '0;
    logic [31:0] cfg_end_i = '0;
    logic        stat_busy_o;
    logic        stat_done_o;
    logic        stat_err_o;
    logic [15:0] stat_rvk_cnt_o;
    logic        tbre_trvk_en_i = 1'b0;
    logic        tbre_trvk_clrtag_i = 1'b0;

    cheri_tbre_engine_if lsu();

    cheri_tbre_engine #(.ChkTimeout(8), .CntW(16)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .cfg_go_i           (cfg_go_i),
        .cfg_abort_i        (cfg_abort_i),
        .cfg_start_i        (cfg_start_i),
        .cfg_end_i          (cfg_end_i),
        .stat_busy_o        (stat_busy_o),
        .stat_done_o        (stat_done_o),
        .stat_err_o         (stat_err_o),
        .stat_rvk_cnt_o     (stat_rvk_cnt_o),
        .lsu                (lsu),
        .tbre_trvk_en_i     (tbre_trvk_en_i),
        .tbre_trvk_clrtag_i (tbre_trvk_clrtag_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        reg_cap_t    wcap;
    } txn_t;

    typedef struct {
        logic [31:0] s, e, errm, rvkm, tmom;
        int          nld, nst, cnt;
        logic        err;
    } vec_t;

    txn_t        q_log[$];
    txn_t        q_exp[$];
    logic [31:0] cur_start = '0;
    logic [31:0] g_errm = '0, g_rvkm = '0, g_tmom = '0;
    bit          g_rand = 1'b0;
    int          g_rsp_fix = -1;
    int          cyc = 0, last_resp_cyc = 0, last_acc_cyc = 0, last_gap = 0;
    int          vectors = 0, miscompares = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic reg_cap_t cap_of(input logic [31:0] a);
        logic [32:0] b;
        b = {1'b1, a ^ 32'hC3A5_0F0F};
        return reg_cap_t'(b);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - cur_start) >> 3);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Model: every slot is loaded; bad loads and missing verdicts flag an error,
    // revoked slots get a store of the loaded word with the tag cleared.
    task automatic build_exp(input logic [31:0] s, e, errm, rvkm, tmom, output int cnt, output logic err);
        logic [32:0] a;
        reg_cap_t    c;
        int          i;
        q_exp.delete();
        cnt = 0;
        err = 1'b0;
        i   = 0;
        a   = {1'b0, s & ~32'h7};
        while (a < {1'b0, e & ~32'h7}) begin
            q_exp.push_back('{we: 1'b0, addr: a[31:0], wdata: 32'h0, wcap: NULL_REG_CAP});
            if (errm[i] || tmom[i]) begin
                err = 1'b1;
            end else if (rvkm[i]) begin
                c       = cap_of(a[31:0]);
                c.valid = 1'b0;
                q_exp.push_back('{we: 1'b1, addr: a[31:0], wdata: data_of(a[31:0]), wcap: c});
                cnt++;
            end
            a = a + 33'd8;
            i++;
        end
    endtask

    // LSU and revocation-check stage stand-in, acting once per negedge.
    initial begin : rsp
        bit          seen, pend, pwe, vact;
        logic        vclr;
        logic [31:0] pa;
        int          dly, rcnt, vcnt, ix;
        txn_t        first, cur;
        seen = 0; pend = 0; pwe = 0; vact = 0; vclr = 0; pa = '0;
        dly = 0; rcnt = 0; vcnt = 0;
        lsu.lsu_tbre_req_done_i   = 1'b0;
        lsu.lsu_tbre_resp_valid_i = 1'b0;
        lsu.lsu_tbre_resp_err_i   = 1'b0;
        lsu.rf_wdata_lsu_i        = '0;
        lsu.rf_wcap_lsu_i         = NULL_REG_CAP;
        forever begin
            @(negedge clk_i);
            cyc++;
            lsu.lsu_tbre_req_done_i   = 1'b0;
            lsu.lsu_tbre_resp_valid_i = 1'b0;
            lsu.lsu_tbre_resp_err_i   = 1'b0;
            lsu.rf_wdata_lsu_i        = $urandom();
            lsu.rf_wcap_lsu_i         = reg_cap_t'({1'b1, $urandom()});
            tbre_trvk_en_i            = 1'b0;
            tbre_trvk_clrtag_i        = 1'b0;
            if (g_rand && !vact && (pend || lsu.tbre_lsu_req_o) && $urandom_range(0, 3) == 0) begin
                tbre_trvk_en_i     = 1'b1;
                tbre_trvk_clrtag_i = 1'b1;
            end
            if (vact) begin
                if (vcnt == 0) begin
                    tbre_trvk_en_i     = 1'b1;
                    tbre_trvk_clrtag_i = vclr;
                    vact               = 0;
                end else vcnt--;
            end
            if (pend) begin
                if (rcnt == 0) begin
                    lsu.lsu_tbre_resp_valid_i = 1'b1;
                    pend          = 0;
                    last_resp_cyc = cyc;
                    if (!pwe) begin
                        ix = idx_of(pa);
                        lsu.lsu_tbre_resp_err_i = g_errm[ix];
                        lsu.rf_wdata_lsu_i      = data_of(pa);
                        lsu.rf_wcap_lsu_i       = cap_of(pa);
                        if (!g_errm[ix] && !g_tmom[ix]) begin
                            vact = 1;
                            vcnt = g_rand ? int'($urandom_range(0, 7)) : 2;
                            vclr = g_rvkm[ix];
                        end
                    end
                end else rcnt--;
            end else if (lsu.tbre_lsu_req_o) begin
                cur = '{we: lsu.tbre_lsu_we_o, addr: lsu.tbre_lsu_addr_o,
                        wdata: lsu.tbre_lsu_wdata_o, wcap: lsu.tbre_lsu_wcap_o};
                if (!seen) begin
                    seen     = 1;
                    first    = cur;
                    dly      = int'($urandom_range(0, 2));
                    last_gap = cyc - last_resp_cyc;
                end
                if (dly == 0) begin
                    lsu.lsu_tbre_req_done_i = 1'b1;
                    seen = 0;
                    pend = 1;
                    pwe  = cur.we;
                    pa   = cur.addr;
                    rcnt = (g_rsp_fix >= 0) ? g_rsp_fix : int'($urandom_range(0, 2));
                    last_acc_cyc = cyc;
                    q_log.push_back(cur);
                    chk("req_stable", cur, first);
                end else dly--;
            end else seen = 0;
        end
    end

    // mode 0 plain, 1 abort with go, 2 second go once busy, 3 abort while the first load is outstanding
    task automatic run_sweep(input logic [31:0] s, e, errm, rvkm, tmom, input int mode, output int ndone);
        bit trig, pulsed;
        q_log.delete();
        cur_start = s & ~32'h7;
        g_errm = errm; g_rvkm = rvkm; g_tmom = tmom;
        pulsed = 0;
        @(negedge clk_i);
        cfg_go_i    = 1'b1;
        cfg_abort_i = (mode == 1);
        cfg_start_i = s;
        cfg_end_i   = e;
        @(negedge clk_i);
        cfg_go_i    = 1'b0;
        cfg_abort_i = 1'b0;
        ndone = 0;
        for (int k = 0; k < 3000 && ndone == 0; k++) begin
            if (stat_done_o) ndone++;
            else begin
                trig        = mode >= 2 && q_log.size() == 1 && cyc > last_acc_cyc && !pulsed;
                cfg_go_i    = trig && mode == 2;
                cfg_abort_i = trig && mode == 3;
                if (trig) begin
                    pulsed      = 1;
                    cfg_start_i = 32'h900;
                    cfg_end_i   = 32'h990;
                end
                @(negedge clk_i);
                cfg_go_i    = 1'b0;
                cfg_abort_i = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk_i);
            if (stat_done_o) ndone++;
        end
    endtask

    task automatic check_run(input string nm, input int ndone, input int ecnt, input logic eerr);
        chk({nm, "/done_pulses"}, 64'(ndone), 64'd1);
        chk({nm, "/busy_after"}, 64'(stat_busy_o), 64'd0);
        chk({nm, "/rvk_cnt"}, 64'(stat_rvk_cnt_o), 64'(ecnt));
        chk({nm, "/err"}, 64'(stat_err_o), 64'(eerr));
        chk({nm, "/n_txn"}, 64'(q_log.size()), 64'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < q_log.size(); i++) begin
            chk({nm, "/txn_we"}, 64'(q_log[i].we), 64'(q_exp[i].we));
            chk({nm, "/txn_addr"}, 64'(q_log[i].addr), 64'(q_exp[i].addr));
            if (q_exp[i].we) begin
                chk({nm, "/st_wdata"}, 64'(q_log[i].wdata), 64'(q_exp[i].wdata));
                chk({nm, "/st_wcap"}, 64'(q_log[i].wcap), 64'(q_exp[i].wcap));
            end
        end
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        tbl[9];
        int          ndone, ecnt, nld, nst, nslot;
        logic        eerr;
        logic [31:0] s, e;
        tbl[0] = '{32'h8000_0000, 32'h8000_0018, 32'h0, 32'h0, 32'h0, 3, 0, 0, 1'b0};
        tbl[1] = '{32'h8000_0000, 32'h8000_0018, 32'h0, 32'h2, 32'h0, 3, 1, 1, 1'b0};
        tbl[2] = '{32'h0000_0100, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1'b0};
        tbl[3] = '{32'h0000_0000, 32'h0000_0020, 32'h4, 32'h0, 32'h0, 4, 0, 0, 1'b1};
        tbl[4] = '{32'h0000_0040, 32'h0000_0050, 32'h0, 32'h0, 32'h1, 2, 0, 0, 1'b1};
        tbl[5] = '{32'h0000_1007, 32'h0000_1020, 32'h0, 32'h9, 32'h0, 4, 2, 2, 1'b0};
        tbl[6] = '{32'h0000_0200, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1'b0};
        tbl[7] = '{32'hFFFF_FFE8, 32'hFFFF_FFFF, 32'h0, 32'h3, 32'h0, 2, 2, 2, 1'b0};
        tbl[8] = '{32'h0000_0500, 32'h0000_0538, 32'h2, 32'h44, 32'h8, 7, 2, 2, 1'b1};

        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_req", 64'(lsu.tbre_lsu_req_o), 64'd0);
        chk("rst_we", 64'(lsu.tbre_lsu_we_o), 64'd0);
        chk("rst_addr", 64'(lsu.tbre_lsu_addr_o), 64'd0);
        chk("rst_wcap", 64'(lsu.tbre_lsu_wcap_o), 64'(NULL_REG_CAP));
        chk("rst_busy", 64'(stat_busy_o), 64'd0);
        chk("rst_done", 64'(stat_done_o), 64'd0);
        chk("rst_err", 64'(stat_err_o), 64'd0);
        chk("rst_cnt", 64'(stat_rvk_cnt_o), 64'd0);

        // Empty range: done pulses the cycle after go, for exactly one cycle.
        cfg_go_i = 1'b1; cfg_start_i = 32'h100; cfg_end_i = 32'h100;
        @(negedge clk_i);
        cfg_go_i = 1'b0;
        chk("empty_done", 64'(stat_done_o), 64'd1);
        chk("empty_req", 64'(lsu.tbre_lsu_req_o), 64'd0);
        @(negedge clk_i);
        chk("empty_done_end", 64'(stat_done_o), 64'd0);
        chk("empty_busy_end", 64'(stat_busy_o), 64'd0);

        for (int i = 0; i < 9; i++) begin
            build_exp(tbl[i].s, tbl[i].e, tbl[i].errm, tbl[i].rvkm, tbl[i].tmom, ecnt, eerr);
            run_sweep(tbl[i].s, tbl[i].e, tbl[i].errm, tbl[i].rvkm, tbl[i].tmom, 0, ndone);
            nld = 0; nst = 0;
            foreach (q_log[j]) if (q_log[j].we) nst++; else nld++;
            chk($sformatf("tbl%0d/n_loads", i), 64'(nld), 64'(tbl[i].nld));
            chk($sformatf("tbl%0d/n_stores", i), 64'(nst), 64'(tbl[i].nst));
            chk($sformatf("tbl%0d/cnt", i), 64'(stat_rvk_cnt_o), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d/err", i), 64'(stat_err_o), 64'(tbl[i].err));
            check_run($sformatf("tbl%0d", i), ndone, ecnt, eerr);
        end

        // Withheld verdict: resp, 8 idle check cycles, NEXT, then the next load request.
        build_exp(32'h40, 32'h50, 32'h0, 32'h0, 32'h1, ecnt, eerr);
        run_sweep(32'h40, 32'h50, 32'h0, 32'h0, 32'h1, 0, ndone);
        check_run("timeout", ndone, ecnt, eerr);
        chk("timeout_gap", 64'(last_gap), 64'd10);

        // go and abort together: go wins and the sweep runs to the end.
        build_exp(32'h600, 32'h610, 32'h0, 32'h0, 32'h0, ecnt, eerr);
        run_sweep(32'h600, 32'h610, 32'h0, 32'h0, 32'h0, 1, ndone);
        check_run("go_abort", ndone, ecnt, eerr);

        // A second go while busy must not restart or retarget the sweep.
        build_exp(32'h700, 32'h718, 32'h0, 32'h1, 32'h0, ecnt, eerr);
        run_sweep(32'h700, 32'h718, 32'h0, 32'h1, 32'h0, 2, ndone);
        check_run("go_busy", ndone, ecnt, eerr);

        // Abort while the first of 4 loads is outstanding; a revoked slot still gets its store-back.
        g_rsp_fix = 3;
        for (int r = 0; r < 2; r++) begin
            build_exp(32'h300, 32'h308, 32'h0, 32'(r), 32'h0, ecnt, eerr);
            run_sweep(32'h300, 32'h320, 32'h0, 32'(r), 32'h0, 3, ndone);
            check_run($sformatf("abort_rvk%0d", r), ndone, ecnt, eerr);
        end
        g_rsp_fix = -1;

        // Random sweeps with random verdict latency and stray verdicts outside the check window.
        g_rand = 1'b1;
        for (int n = 0; n < 10; n++) begin
            s     = 32'h2000 + 32'($urandom_range(0, 255)) * 8 + 32'($urandom_range(0, 7));
            nslot = int'($urandom_range(0, 12));
            e     = (s & ~32'h7) + 32'(nslot) * 8 + 32'($urandom_range(0, 7));
            g_errm = $urandom() & $urandom() & $urandom();
            g_rvkm = $urandom();
            g_tmom = $urandom() & $urandom() & $urandom();
            build_exp(s, e, g_errm, g_rvkm, g_tmom, ecnt, eerr);
            run_sweep(s, e, g_errm, g_rvkm, g_tmom, 0, ndone);
            check_run($sformatf("rand%0d", n), ndone, ecnt, eerr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
